// File: rtl/module_seg_pkg.sv
// Shared types and active-high seven-segment glyph constants for the
// display subsystem decoders. Bit order in every glyph: {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_A     = 7'h77;
    localparam seg7_t SEG_B     = 7'h7C;
    localparam seg7_t SEG_C     = 7'h39;
    localparam seg7_t SEG_D     = 7'h5E;
    localparam seg7_t SEG_E     = 7'h79;
    localparam seg7_t SEG_F     = 7'h71;
    localparam seg7_t SEG_BLANK = 7'h00;

    // Convert an active-high glyph to the polarity the panel expects.
    function automatic seg7_t seg_polarity(input seg7_t hi, input bit active_low);
        seg7_t res;
        if (active_low) begin
            res = ~hi;
        end else begin
            res = hi;
        end
        return res;
    endfunction

endpackage : seg_pkg

// File: rtl/module_seg_if.sv
// Digit/segment bundle for the four-digit seven-segment decoder.
// master drives BCD digits and observes segments; slave is the decoder side.
interface module_seg_if;
    import seg_pkg::*;

    bcd_t  unidades_input;
    bcd_t  decenas_input;
    bcd_t  centenas_input;
    bcd_t  milesimas_input;
    seg7_t seg_unidades;
    seg7_t seg_decenas;
    seg7_t seg_centenas;
    seg7_t seg_milesimas;

    modport master (
        output unidades_input, decenas_input, centenas_input, milesimas_input,
        input  seg_unidades, seg_decenas, seg_centenas, seg_milesimas
    );

    modport slave (
        input  unidades_input, decenas_input, centenas_input, milesimas_input,
        output seg_unidades, seg_decenas, seg_centenas, seg_milesimas
    );

endinterface : module_seg_if

// File: rtl/module_seg_bcd_to_seg7.sv
// Combinational single-digit decoder, active-high output.
// Optional build macro HEX_DIGITS_EN: codes 10-15 show A b C d E F
// instead of blank.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  bcd_t  in,
    output seg7_t out
);

    // Glyph lookup; anything not a displayable code stays dark.
    always_comb begin
        out = SEG_BLANK;
        case (in)
            4'd0:    out = SEG_0;
            4'd1:    out = SEG_1;
            4'd2:    out = SEG_2;
            4'd3:    out = SEG_3;
            4'd4:    out = SEG_4;
            4'd5:    out = SEG_5;
            4'd6:    out = SEG_6;
            4'd7:    out = SEG_7;
            4'd8:    out = SEG_8;
            4'd9:    out = SEG_9;
`ifdef HEX_DIGITS_EN
            4'd10:   out = SEG_A;
            4'd11:   out = SEG_B;
            4'd12:   out = SEG_C;
            4'd13:   out = SEG_D;
            4'd14:   out = SEG_E;
            4'd15:   out = SEG_F;
`else
            4'd10,
            4'd11,
            4'd12,
            4'd13,
            4'd14,
            4'd15:   out = SEG_BLANK;
`endif
            default: out = SEG_BLANK;
        endcase
    end

endmodule : bcd_to_seg7

// File: rtl/module_seg.sv
// Registered four-digit BCD to seven-segment decoder. All four digits are
// decoded in parallel and captured on the same rising edge (1-cycle latency).
// Reset (rst, active-low, asynchronous) blanks every digit immediately.
// Optional build macro HEX_DIGITS_EN (handled in bcd_to_seg7) enables A-F.
module module_seg
    import seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  bcd_t  unidades_input,
    input  bcd_t  decenas_input,
    input  bcd_t  centenas_input,
    input  bcd_t  milesimas_input,
    output seg7_t seg_unidades,
    output seg7_t seg_decenas,
    output seg7_t seg_centenas,
    output seg7_t seg_milesimas
);

    // Dark pattern in panel polarity.
    localparam seg7_t SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    bcd_t  digit_s [4];
    seg7_t hi_s    [4];
    seg7_t seg_d   [4];
    seg7_t seg_q   [4];

    assign digit_s[0] = unidades_input;
    assign digit_s[1] = decenas_input;
    assign digit_s[2] = centenas_input;
    assign digit_s[3] = milesimas_input;

    for (genvar g = 0; g < 4; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .in  (digit_s[g]),
            .out (hi_s[g])
        );
    end

    // Apply panel polarity to each decoded glyph.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            seg_d[i] = seg_polarity(hi_s[i], SEG_ACTIVE_LOW);
        end
    end

    // Output registers; reset forces every digit dark without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                seg_q[i] <= SEG_OFF;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    assign seg_unidades  = seg_q[0];
    assign seg_decenas   = seg_q[1];
    assign seg_centenas  = seg_q[2];
    assign seg_milesimas = seg_q[3];

endmodule : module_seg

// File: tb/tb_module_seg.sv
// Self-checking bench for module_seg (default SEG_ACTIVE_LOW = 1).
module tb_module_seg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    module_seg_if bus ();

    module_seg dut (
        .clk             (clk),
        .rst             (rst),
        .unidades_input  (bus.unidades_input),
        .decenas_input   (bus.decenas_input),
        .centenas_input  (bus.centenas_input),
        .milesimas_input (bus.milesimas_input),
        .seg_unidades    (bus.seg_unidades),
        .seg_decenas     (bus.seg_decenas),
        .seg_centenas    (bus.seg_centenas),
        .seg_milesimas   (bus.seg_milesimas)
    );

    always #5 clk = ~clk;

    // Reference glyph table, active-high, indexed by digit code.
`ifdef HEX_DIGITS_EN
    logic [6:0] hi_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
    logic [6:0] hi_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif

    function automatic logic [6:0] model_lo(input logic [3:0] v);
        return ~hi_tab[v];
    endfunction

    // Expected outputs: what the display should show given reset and the
    // digits present at the last clock edge.
    logic [6:0] exp_u, exp_d, exp_c, exp_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_u <= 7'h7F; exp_d <= 7'h7F; exp_c <= 7'h7F; exp_m <= 7'h7F;
        end else begin
            exp_u <= model_lo(bus.unidades_input);
            exp_d <= model_lo(bus.decenas_input);
            exp_c <= model_lo(bus.centenas_input);
            exp_m <= model_lo(bus.milesimas_input);
        end
    end

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_units",     bus.seg_unidades,  exp_u);
            chk("cyc_tens",      bus.seg_decenas,   exp_d);
            chk("cyc_hundreds",  bus.seg_centenas,  exp_c);
            chk("cyc_thousands", bus.seg_milesimas, exp_m);
        end
    end

    task automatic drive(input logic [3:0] m, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] u);
        bus.milesimas_input = m;
        bus.centenas_input  = c;
        bus.decenas_input   = d;
        bus.unidades_input  = u;
    endtask

    // Apply digits mid-low-phase, then sample just after the capturing edge.
    task automatic step(input logic [3:0] m, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] u);
        @(negedge clk);
        #1;
        drive(m, c, d, u);
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [6:0] m, input logic [6:0] c,
                        input logic [6:0] d, input logic [6:0] u);
        chk({name, "_m"}, bus.seg_milesimas, m);
        chk({name, "_c"}, bus.seg_centenas,  c);
        chk({name, "_d"}, bus.seg_decenas,   d);
        chk({name, "_u"}, bus.seg_unidades,  u);
    endtask

    initial begin
        logic [3:0] r [4];
        drive(4'd8, 4'd8, 4'd8, 4'd8);
        rst = 1'b0;

        // Reset held across several edges with varied inputs.
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            chk4("rst_hold", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        end

        // Release reset; first decode on the following edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive(4'd7, 4'd6, 4'd0, 4'd9);
        chk4("rst_release_pre", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        @(posedge clk);
        #1;
        chk4("v7609", 7'h78, 7'h02, 7'h40, 7'h10);

        step(4'd3, 4'd1, 4'd9, 4'd3);
        chk4("v3193", 7'h30, 7'h79, 7'h10, 7'h30);
        step(4'd0, 4'd0, 4'd9, 4'd4);
        chk4("v0094", 7'h40, 7'h40, 7'h10, 7'h19);

        // Independent sweep of each digit position.
        for (int pos = 0; pos < 4; pos++) begin
            for (int v = 0; v < 10; v++) begin
                r[0] = 4'd5; r[1] = 4'd5; r[2] = 4'd5; r[3] = 4'd5;
                r[pos] = 4'(v);
                step(r[3], r[2], r[1], r[0]);
            end
        end

        // Non-decimal codes.
        step(4'd10, 4'd11, 4'd12, 4'd13);
`ifdef HEX_DIGITS_EN
        chk4("hex_abcd", 7'h08, 7'h03, 7'h46, 7'h21);
`else
        chk4("hex_abcd", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`endif
        step(4'd14, 4'd15, 4'd0, 4'd1);
`ifdef HEX_DIGITS_EN
        chk4("hex_ef01", 7'h06, 7'h0E, 7'h40, 7'h79);
`else
        chk4("hex_ef01", 7'h7F, 7'h7F, 7'h40, 7'h79);
`endif

        // Asynchronous reset while showing 8888.
        step(4'd8, 4'd8, 4'd8, 4'd8);
        chk4("all8", 7'h00, 7'h00, 7'h00, 7'h00);
        #2;
        rst = 1'b0;
        #1;
        chk4("async_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk4("after_async", 7'h00, 7'h00, 7'h00, 7'h00);

        // Random traffic with occasional short asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                #1;
                chk4("rand_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
                #1;
                rst = 1'b1;
            end else begin
                rst = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_module_seg
